motor_array: RTL and testbench
==============================

MOTOR_ARRAY -- requirements
Module: motor_array

Interface
REQ-001 SHALL have parameter N_CH, default 2: number of independent motor channels (1..8).
REQ-002 SHALL have parameter CNT_W, default 10: width of the PWM counter and duty words.
REQ-003 SHALL have parameter PERIOD, default 1000: PWM period in clk_100kHz cycles, 2..2^CNT_W-1.
REQ-004 SHALL have parameter DEAD_PER, default 2: dead-time on direction reversal, in whole PWM periods, >=1.
REQ-005 SHALL have parameter RAMP_STEP, default 10: maximum duty change per period when ramping.
REQ-006 SHALL have port clk_100kHz, input, 1: sole clock.
REQ-007 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port direction, input, 2*N_CH: per channel, 2'b11 forward, 2'b00 backward, 2'b01/2'b10 halt.
REQ-009 SHALL have port duty, input, N_CH*CNT_W: per-channel target high-time in cycles per period.
REQ-010 SHALL have port en, output, 2*N_CH: per-channel bridge enables, 2'b10 forward, 2'b01 backward, 2'b00 off.
REQ-011 SHALL have port pwm, output, N_CH: per-channel PWM.
REQ-012 SHALL have port period_tick, output, 1: one-cycle pulse on the last cycle of each period.

Function
REQ-013 SHALL run one shared counter cnt: 0 to PERIOD-1, then wrap to 0; period_tick=1 when cnt==PERIOD-1.
REQ-014 SHALL sample direction and duty only on period_tick cycles; mid-period input changes SHALL NOT affect outputs.
REQ-015 SHALL clamp a sampled duty greater than PERIOD to PERIOD (100 % high).
REQ-016 SHALL drive pwm[i] registered, high in the cycle after cnt < duty_applied[i], so pwm has one-cycle latency from cnt.
REQ-017 SHALL run per channel FSM states HALT, FWD, BWD, DEAD; all transitions only on period_tick.
REQ-018 HALT: en=00, pwm=0, duty_applied=0; sampled fwd -> FWD, bwd -> BWD, halt -> HALT.
REQ-019 FWD/BWD: en=10/01; sampled halt -> HALT; same direction -> stay; opposite direction -> DEAD.
REQ-020 DEAD: en=00, pwm=0, duty_applied=0; after DEAD_PER periods enter the last sampled direction (or HALT if halt sampled).
REQ-021 SHALL update en on the same cycle as the first pwm cycle of the new period (no en/pwm skew).
REQ-022 SHALL treat duty=0 as pwm constantly 0 with en still asserted in FWD/BWD.
REQ-023 SHALL keep channels fully independent except for the shared counter.

Reset
REQ-024 SHALL on rst_n low immediately set cnt=0, en=0, pwm=0, period_tick=0, all FSMs HALT, all duty_applied=0.
REQ-025 SHALL start the first period at cnt=0 on the first clock after rst_n deasserts; reset mid-period SHALL abort without glitch.

Configuration
REQ-026 SHALL provide macro MOTOR_RAMP_EN: when defined, duty_applied moves toward the sampled target by at most RAMP_STEP per period (both up and down, no overshoot).
REQ-027 Without MOTOR_RAMP_EN, duty_applied SHALL equal the clamped sampled target from the next period; RAMP_STEP SHALL be ignored.
REQ-028 With MOTOR_RAMP_EN, leaving DEAD or HALT SHALL ramp from 0.

Structure
REQ-029 SHALL place direction encodings (FWD=2'b11, BWD=2'b00), en encodings and the FSM state enum in shared package motor_pkg.
REQ-030 SHALL implement per-channel logic in sub-module motor_channel, instantiated N_CH times; counter stays in motor_array.

Verification
REQ-031 Reset, direction=11, duty=200, PERIOD=1000 -> from period 2, en=10, pwm high exactly 200 cycles per period.
REQ-032 duty changed 200->600 at cnt=500 -> current period unchanged; next period pwm high 600 cycles.
REQ-033 Forward to backward, DEAD_PER=2 -> en=00, pwm=0 for exactly 2000 cycles, then en=01.
REQ-034 duty=1023 with PERIOD=1000 -> pwm continuously high; duty=0 -> pwm low, en=10.
REQ-035 MOTOR_RAMP_EN, RAMP_STEP=10, target 0->50 -> high-times 10,20,30,40,50 in successive periods.
REQ-036 rst_n low at cnt=437 while running -> en=0, pwm=0 same cycle; after release cnt restarts at 0, channel in HALT.

Source files
------------

// File: rtl/motor_pkg.sv
// ---------------------------------------------------------------------------
// motor_pkg
// Shared definitions for the motor_array slice: direction input encodings,
// bridge-enable output encodings, the per-channel FSM state type and a helper
// that maps a state onto its bridge enables.
// Optional feature macro used elsewhere in the slice: MOTOR_RAMP_EN.
// ---------------------------------------------------------------------------
package motor_pkg;

   // Direction request encodings; both remaining codes (01/10) mean halt.
   localparam logic [1:0] DIR_FWD = 2'b11;
   localparam logic [1:0] DIR_BWD = 2'b00;

   // H-bridge enable encodings.
   localparam logic [1:0] EN_FWD  = 2'b10;
   localparam logic [1:0] EN_BWD  = 2'b01;
   localparam logic [1:0] EN_OFF  = 2'b00;

   typedef enum logic [1:0] {
      ST_HALT,
      ST_FWD,
      ST_BWD,
      ST_DEAD
   } motor_state_e;

   function automatic logic [1:0] state_to_en(motor_state_e s);
      case (s)
         ST_FWD:  return EN_FWD;
         ST_BWD:  return EN_BWD;
         default: return EN_OFF;
      endcase
   endfunction

endpackage

// File: rtl/motor_if.sv
// ---------------------------------------------------------------------------
// motor_if / motor_ch_if
// motor_if bundles the array-level control and status vectors
// (direction, duty, en, pwm, period_tick) so a controller can hold them as a
// single object; master drives the requests, slave drives the status.
// motor_ch_if is the per-channel link between the shared counter in
// motor_array (master) and one motor_channel (slave):
//   tick  period boundary strobe      cnt  shared PWM counter value
//   dir   raw direction request       duty raw duty request
//   en    registered bridge enables   pwm  registered PWM output
// ---------------------------------------------------------------------------
interface motor_if #(
   parameter int N_CH  = 2,
   parameter int CNT_W = 10
);
   logic [2*N_CH-1:0]     direction;
   logic [N_CH*CNT_W-1:0] duty;
   logic [2*N_CH-1:0]     en;
   logic [N_CH-1:0]       pwm;
   logic                  period_tick;

   modport master (output direction, duty, input en, pwm, period_tick);
   modport slave  (input direction, duty, output en, pwm, period_tick);
endinterface

interface motor_ch_if #(
   parameter int CNT_W = 10
);
   logic             tick;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       dir;
   logic [CNT_W-1:0] duty;
   logic [1:0]       en;
   logic             pwm;

   modport master (output tick, cnt, dir, duty, input en, pwm);
   modport slave  (input tick, cnt, dir, duty, output en, pwm);
endinterface

// File: rtl/motor_channel.sv
// ---------------------------------------------------------------------------
// motor_channel
// One independent motor channel: HALT/FWD/BWD/DEAD state machine, the
// applied duty word and the registered pwm/en outputs.
// Ports:
//   clk_100kHz  clock
//   rst_n       asynchronous active-low reset
//   ch          motor_ch_if.slave (tick, cnt, dir, duty in; en, pwm out)
// Macro MOTOR_RAMP_EN: when defined, the applied duty slews toward the
// sampled target by at most RAMP_STEP per period instead of jumping.
// ---------------------------------------------------------------------------
module motor_channel
   import motor_pkg::*;
#(
   parameter int CNT_W     = 10,
   parameter int PERIOD    = 1000,
   parameter int DEAD_PER  = 2,
   parameter int RAMP_STEP = 10
) (
   input  logic         clk_100kHz,
   input  logic         rst_n,
   motor_ch_if.slave    ch
);

   localparam int               DW        = (DEAD_PER > 1) ? $clog2(DEAD_PER) : 1;
   localparam logic [DW-1:0]    DEAD_LAST = DW'(DEAD_PER - 1);
   localparam logic [CNT_W-1:0] PERIOD_W  = CNT_W'(PERIOD);

   motor_state_e     state_q, state_d;
   logic [CNT_W-1:0] duty_applied_q, duty_applied_d;
   logic [DW-1:0]    dead_cnt_q, dead_cnt_d;
   logic [1:0]       en_q, en_d;
   logic             pwm_q, pwm_d;

   logic [CNT_W-1:0] tgt;
   logic [CNT_W-1:0] step_duty;
   logic             dir_fwd, dir_bwd;

   // Next state and applied duty. Everything only moves on the period tick,
   // so inputs changing mid-period are invisible until the next boundary.
   // duty_applied_q is held at zero in HALT and DEAD, so using it as the
   // ramp base makes a channel leaving those states start from zero.
   always_comb begin
      state_d        = state_q;
      duty_applied_d = duty_applied_q;
      dead_cnt_d     = dead_cnt_q;
      dir_fwd        = (ch.dir == DIR_FWD);
      dir_bwd        = (ch.dir == DIR_BWD);
      tgt            = (ch.duty > PERIOD_W) ? PERIOD_W : ch.duty;
`ifdef MOTOR_RAMP_EN
      if (tgt > duty_applied_q) begin
         step_duty = ((32'(tgt) - 32'(duty_applied_q)) > 32'(RAMP_STEP)) ?
                     CNT_W'(32'(duty_applied_q) + 32'(RAMP_STEP)) : tgt;
      end else begin
         step_duty = ((32'(duty_applied_q) - 32'(tgt)) > 32'(RAMP_STEP)) ?
                     CNT_W'(32'(duty_applied_q) - 32'(RAMP_STEP)) : tgt;
      end
`else
      step_duty = tgt;
`endif
      if (ch.tick) begin
         case (state_q)
            ST_HALT: begin
               if (dir_fwd) begin
                  state_d        = ST_FWD;
                  duty_applied_d = step_duty;
               end else if (dir_bwd) begin
                  state_d        = ST_BWD;
                  duty_applied_d = step_duty;
               end
            end
            ST_FWD, ST_BWD: begin
               if ((dir_fwd && state_q == ST_FWD) || (dir_bwd && state_q == ST_BWD)) begin
                  duty_applied_d = step_duty;
               end else if (dir_fwd || dir_bwd) begin
                  state_d        = ST_DEAD;
                  duty_applied_d = '0;
                  dead_cnt_d     = '0;
               end else begin
                  state_d        = ST_HALT;
                  duty_applied_d = '0;
               end
            end
            ST_DEAD: begin
               if (dead_cnt_q == DEAD_LAST) begin
                  if (dir_fwd) begin
                     state_d        = ST_FWD;
                     duty_applied_d = step_duty;
                  end else if (dir_bwd) begin
                     state_d        = ST_BWD;
                     duty_applied_d = step_duty;
                  end else begin
                     state_d        = ST_HALT;
                  end
               end else begin
                  dead_cnt_d = dead_cnt_q + DW'(1);
               end
            end
            default: begin
               state_d        = ST_HALT;
               duty_applied_d = '0;
            end
         endcase
      end
   end

   // Output stage: en and pwm are both registered one cycle behind the state
   // and counter, so a new state's enables appear on the same cycle as the
   // first pwm cycle of the new period.
   always_comb begin
      en_d  = state_to_en(state_q);
      pwm_d = (ch.cnt < duty_applied_q);
   end

   // All channel state lives here; reset drops outputs immediately.
   always_ff @(posedge clk_100kHz or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_HALT;
         duty_applied_q <= '0;
         dead_cnt_q     <= '0;
         en_q           <= EN_OFF;
         pwm_q          <= 1'b0;
      end else begin
         state_q        <= state_d;
         duty_applied_q <= duty_applied_d;
         dead_cnt_q     <= dead_cnt_d;
         en_q           <= en_d;
         pwm_q          <= pwm_d;
      end
   end

   assign ch.en  = en_q;
   assign ch.pwm = pwm_q;

endmodule

// File: rtl/motor_array.sv
// ---------------------------------------------------------------------------
// motor_array
// N_CH independent PWM motor channels sharing one period counter.
// Ports:
//   clk_100kHz   clock
//   rst_n        asynchronous active-low reset
//   direction    2 bits/channel request: 11 fwd, 00 bwd, 01/10 halt
//   duty         CNT_W bits/channel target high-time per period
//   en           2 bits/channel bridge enables: 10 fwd, 01 bwd, 00 off
//   pwm          1 bit/channel PWM output
//   period_tick  high on the last cycle of every period
// Macro MOTOR_RAMP_EN (see motor_channel) enables duty ramping.
// ---------------------------------------------------------------------------
module motor_array
   import motor_pkg::*;
#(
   parameter int N_CH      = 2,
   parameter int CNT_W     = 10,
   parameter int PERIOD    = 1000,
   parameter int DEAD_PER  = 2,
   parameter int RAMP_STEP = 10
) (
   input  logic                  clk_100kHz,
   input  logic                  rst_n,
   input  logic [2*N_CH-1:0]     direction,
   input  logic [N_CH*CNT_W-1:0] duty,
   output logic [2*N_CH-1:0]     en,
   output logic [N_CH-1:0]       pwm,
   output logic                  period_tick
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PERIOD - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Shared period counter: 0 .. PERIOD-1, then wrap.
   always_comb begin
      cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk_100kHz or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign period_tick = (cnt_q == LAST_CNT);

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      motor_ch_if #(.CNT_W(CNT_W)) ch_bus ();

      assign ch_bus.tick = period_tick;
      assign ch_bus.cnt  = cnt_q;
      assign ch_bus.dir  = direction[2*i +: 2];
      assign ch_bus.duty = duty[i*CNT_W +: CNT_W];
      assign en[2*i +: 2] = ch_bus.en;
      assign pwm[i]       = ch_bus.pwm;

      motor_channel #(
         .CNT_W     (CNT_W),
         .PERIOD    (PERIOD),
         .DEAD_PER  (DEAD_PER),
         .RAMP_STEP (RAMP_STEP)
      ) u_channel (
         .clk_100kHz (clk_100kHz),
         .rst_n      (rst_n),
         .ch         (ch_bus)
      );
   end

endmodule

// File: tb/tb_motor_array.sv
// ---------------------------------------------------------------------------
// tb_motor_array
// Directed bench for motor_array (N_CH=2, CNT_W=10, PERIOD=1000, DEAD_PER=2).
// A measurement window covers one full period of pwm as seen at the outputs
// (cnt=1..PERIOD-1 then cnt=0 of the next period, because pwm lags cnt by one
// cycle); in it the bench counts pwm high cycles, records en and counts en
// changes and period ticks.
// Macro MOTOR_RAMP_EN selects the ramp scenario instead of the step scenarios.
// ---------------------------------------------------------------------------
module tb_motor_array;
   import motor_pkg::*;

   localparam int N_CH      = 2;
   localparam int CNT_W     = 10;
   localparam int PERIOD    = 1000;
   localparam int DEAD_PER  = 2;
   localparam int RAMP_STEP = 10;

   logic clk;
   logic rst_n;

   int checks   = 0;
   int failures = 0;

   int hi_cnt     [8][N_CH];
   int en_first   [8][N_CH];
   int en_changes [8][N_CH];
   int tick_cnt   [8];

   typedef struct {
      logic [1:0] dir0;
      int         duty0;
      logic [1:0] dir1;
      int         duty1;
      logic [1:0] en0;
      int         hi0;
      logic [1:0] en1;
      int         hi1;
   } vec_t;

   vec_t vecs [6];

   motor_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus ();

   motor_array #(
      .N_CH      (N_CH),
      .CNT_W     (CNT_W),
      .PERIOD    (PERIOD),
      .DEAD_PER  (DEAD_PER),
      .RAMP_STEP (RAMP_STEP)
   ) dut (
      .clk_100kHz  (clk),
      .rst_n       (rst_n),
      .direction   (bus.direction),
      .duty        (bus.duty),
      .en          (bus.en),
      .pwm         (bus.pwm),
      .period_tick (bus.period_tick)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case a scenario stalls.
   initial begin
      #5000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [1:0] d0, input int u0,
                                input logic [1:0] d1, input int u1);
      bus.direction = {d1, d0};
      bus.duty      = {CNT_W'(u1), CNT_W'(u0)};
   endtask

   // Waits (bounded) until a negedge where period_tick is high.
   task automatic waitTick(input string who);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < PERIOD + 4; i++) begin
         @(negedge clk);
         if (bus.period_tick) begin
            ok = 1'b1;
            break;
         end
      end
      checkOutput({who, "_tick_seen"}, int'(ok), 1);
   endtask

   // Measures np consecutive periods; with do_wait=0 the caller is already
   // at the negedge on which period_tick is high.
   task automatic runPeriods(input int np, input bit do_wait, input string who);
      if (do_wait) waitTick(who);
      @(negedge clk);
      for (int p = 0; p < np; p++) begin
         tick_cnt[p] = 0;
         for (int c = 0; c < N_CH; c++) begin
            hi_cnt[p][c]     = 0;
            en_changes[p][c] = 0;
            en_first[p][c]   = 0;
         end
         for (int k = 0; k < PERIOD; k++) begin
            @(negedge clk);
            if (bus.period_tick) tick_cnt[p]++;
            for (int c = 0; c < N_CH; c++) begin
               if (bus.pwm[c]) hi_cnt[p][c]++;
               if (k == 0) en_first[p][c] = int'(bus.en[2*c +: 2]);
               else if (int'(bus.en[2*c +: 2]) != en_first[p][c]) en_changes[p][c]++;
            end
         end
      end
   endtask

   task automatic checkWindow(input string who, input int p, input int c,
                              input logic [1:0] exp_en, input int exp_hi);
      checkOutput($sformatf("%s_p%0d_ch%0d_en", who, p, c), en_first[p][c], int'(exp_en));
      checkOutput($sformatf("%s_p%0d_ch%0d_high", who, p, c), hi_cnt[p][c], exp_hi);
      checkOutput($sformatf("%s_p%0d_ch%0d_en_stable", who, p, c), en_changes[p][c], 0);
   endtask

   initial begin
      int n;
      int nz;
      bit got;

      // ch0 dir, duty, ch1 dir, duty  ->  expected en/high-time per channel
      vecs[0] = '{DIR_FWD, 200,  2'b01,   300,  EN_FWD, 200,  EN_OFF, 0};
      vecs[1] = '{DIR_FWD, 600,  DIR_BWD, 0,    EN_FWD, 600,  EN_BWD, 0};
      vecs[2] = '{DIR_FWD, 1023, DIR_BWD, 1000, EN_FWD, 1000, EN_BWD, 1000};
      vecs[3] = '{2'b01,   500,  DIR_BWD, 999,  EN_OFF, 0,    EN_BWD, 999};
      vecs[4] = '{DIR_BWD, 1,    2'b10,   700,  EN_BWD, 1,    EN_OFF, 0};
      vecs[5] = '{2'b10,   0,    DIR_FWD, 0,    EN_OFF, 0,    EN_FWD, 0};

      rst_n = 1'b0;
      applyStimulus(2'b01, 0, 2'b01, 0);
      repeat (3) @(negedge clk);
      checkOutput("reset_en",   int'(bus.en), 0);
      checkOutput("reset_pwm",  int'(bus.pwm), 0);
      checkOutput("reset_tick", int'(bus.period_tick), 0);
      rst_n = 1'b1;

`ifdef MOTOR_RAMP_EN
      applyStimulus(DIR_FWD, 50, 2'b01, 0);
      runPeriods(6, 1'b1, "ramp_up");
      checkWindow("ramp_up", 0, 0, EN_FWD, 10);
      checkWindow("ramp_up", 1, 0, EN_FWD, 20);
      checkWindow("ramp_up", 2, 0, EN_FWD, 30);
      checkWindow("ramp_up", 3, 0, EN_FWD, 40);
      checkWindow("ramp_up", 4, 0, EN_FWD, 50);
      checkWindow("ramp_up", 5, 0, EN_FWD, 50);
      applyStimulus(DIR_FWD, 25, 2'b01, 0);
      runPeriods(3, 1'b1, "ramp_dn");
      checkWindow("ramp_dn", 0, 0, EN_FWD, 40);
      checkWindow("ramp_dn", 1, 0, EN_FWD, 30);
      checkWindow("ramp_dn", 2, 0, EN_FWD, 25);
`else
      // Table of steady-state vectors, each measured in the period after
      // the boundary that samples it.
      for (int v = 0; v < 6; v++) begin
         applyStimulus(vecs[v].dir0, vecs[v].duty0, vecs[v].dir1, vecs[v].duty1);
         runPeriods(1, 1'b1, $sformatf("vec%0d", v));
         checkWindow($sformatf("vec%0d", v), 0, 0, vecs[v].en0, vecs[v].hi0);
         checkWindow($sformatf("vec%0d", v), 0, 1, vecs[v].en1, vecs[v].hi1);
         checkOutput($sformatf("vec%0d_ticks", v), tick_cnt[0], 1);
      end

      // Duty change in the middle of a running period only lands next period.
      applyStimulus(DIR_FWD, 200, DIR_FWD, 0);
      fork
         runPeriods(2, 1'b1, "midchg");
         begin
            waitTick("midchg_drv");
            repeat (501) @(negedge clk);
            bus.duty[CNT_W-1:0] = CNT_W'(600);
         end
      join
      checkWindow("midchg", 0, 0, EN_FWD, 200);
      checkWindow("midchg", 1, 0, EN_FWD, 600);

      // Reversal: two full dead periods, then backward.
      applyStimulus(DIR_BWD, 300, DIR_FWD, 1000);
      runPeriods(4, 1'b1, "rev");
      checkWindow("rev", 0, 0, EN_OFF, 0);
      checkWindow("rev", 1, 0, EN_OFF, 0);
      checkWindow("rev", 2, 0, EN_BWD, 300);
      checkWindow("rev", 3, 0, EN_BWD, 300);
      checkWindow("rev", 0, 1, EN_FWD, 1000);

      // Reset asserted at cnt=437 while both channels are driving.
      waitTick("rst");
      repeat (438) @(negedge clk);
      checkOutput("prerst_en1",  int'(bus.en[3:2]), int'(EN_FWD));
      checkOutput("prerst_pwm1", int'(bus.pwm[1]), 1);
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_en",   int'(bus.en), 0);
      checkOutput("midrst_pwm",  int'(bus.pwm), 0);
      checkOutput("midrst_tick", int'(bus.period_tick), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      n   = 0;
      nz  = 0;
      got = 1'b0;
      for (int i = 0; i < PERIOD + 4; i++) begin
         @(negedge clk);
         n++;
         if (bus.en != '0) nz++;
         if (bus.period_tick) begin
            got = 1'b1;
            break;
         end
      end
      checkOutput("postrst_tick_seen", int'(got), 1);
      checkOutput("postrst_cycles_to_tick", n, PERIOD - 1);
      checkOutput("postrst_halt_en_samples", nz, 0);
      runPeriods(1, 1'b0, "postrst");
      checkWindow("postrst", 0, 0, EN_BWD, 300);
      checkWindow("postrst", 0, 1, EN_FWD, 1000);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
